axi_wr_tracker: RTL and testbench
=================================

# axi_wr_tracker

Parametrised AXI write-path slave endpoint. It accepts up to MAX_OUT outstanding write bursts, generates a per-beat address for FIXED/INCR/WRAP bursts, and checks WLAST against AWLEN. It returns in-order B responses carrying the burst ID. It sits between the AXI interconnect and a simple single-beat write backend, and extends the AW/W/B channel FSMs with IDs, multiple outstanding bursts, address generation and error responses.

## Interface
- IDW, 4, ID width
- AW, 32, address width
- DW, 64, data width; power of 2, 8..1024
- MAX_OUT, 4, maximum outstanding bursts; power of 2, ≥2
- axi_aclk  in  1  clock
- axi_areset  in  1  synchronous, active-high reset
- s_awid/s_awaddr/s_awlen/s_awsize/s_awburst  in  IDW/AW/8/3/2  write address
- s_awvalid  in  1; s_awready  out  1
- s_wdata/s_wstrb/s_wlast  in  DW/DW/8/1  write data
- s_wvalid  in  1; s_wready  out  1
- s_bid/s_bresp  out  IDW/2  write response
- s_bvalid  out  1; s_bready  in  1
- wr_en  out  1  backend beat strobe
- wr_addr/wr_data/wr_strb  out  AW/DW/DW/8  backend beat
- err_wlast  out  1  sticky: WLAST mismatch seen
- outstanding  out  $clog2(MAX_OUT)+1  count of bursts accepted on AW and not yet completed on B

## Operation
- AW queue: FIFO of MAX_OUT entries {id, addr, len, size, burst, bad}.
  - s_awready = (outstanding < MAX_OUT), from registered state only.
  - bad = size > log2(DW/8), or burst==2'b11, or WRAP with len not in {1,3,7,15}, or INCR crossing a 4 KB boundary.
- W FSM states: IDLE, DATA.
  - IDLE→DATA when the AW queue is non-empty. Load the head entry into the beat counter and address register.
  - s_wready = (state==DATA).
  - Each W handshake: wr_en=!bad, wr_addr=current beat address, data/strb passed through; beat counter +1.
  - Beat address arithmetic:
    - FIXED: unchanged.
    - INCR: addr_aligned + (beat<<size).
    - WRAP: wrap_base | ((addr + (beat<<size)) & (((len+1)<<size)-1)), where wrap_base = addr & ~(((len+1)<<size)-1).
    - All arithmetic is in AW bits; the first beat uses the unaligned address.
  - Last counted beat (beat==len): pop the AW entry and push {id, resp} to the B queue.
    - resp=2'b10 (SLVERR) if bad or WLAST mismatch; else 2'b00.
    - Next state is DATA if another AW entry is already present, else IDLE.
  - WLAST mismatch: s_wlast=1 before beat len, or s_wlast=0 on beat len. Set err_wlast and mark the burst SLVERR. The beat counter is authoritative and the burst always ends at beat len.
- B queue: FIFO of MAX_OUT entries. s_bvalid = non-empty; head drives s_bid/s_bresp and is popped on the s_bvalid&s_bready handshake. Cannot overflow because outstanding bounds it.
- outstanding: +1 on AW handshake, −1 on B handshake, unchanged when both occur in the same cycle.

## Timing
- Reset values: s_awready=1, s_wready=0, s_bvalid=0, s_bid=0, s_bresp=0, wr_en=0, wr_addr=0, wr_data=0, wr_strb=0, err_wlast=0, outstanding=0. Both queues empty; W FSM in IDLE.
- Reset mid-burst drops all queued and in-flight state in one cycle. No B response is produced for dropped bursts.
- AW handshake at cycle t: s_wready earliest at t+1. There is no AW→W bypass, and W beats before any AW are back-pressured.
- W beat handshake at t: wr_en/wr_addr/wr_data valid at t+1 for exactly one cycle. This is a registered, 1-cycle latency; the backend never stalls.
- Last beat at t: s_bvalid earliest at t+1. s_bvalid, s_bid and s_bresp stay stable until s_bready.
- Back-to-back bursts: the last beat of burst k at t and the first beat of burst k+1 at t+1 complete with no bubble when the next AW entry is queued.
- When outstanding==MAX_OUT, s_awready=0. A B handshake in cycle t raises s_awready at t+1.
- Outputs do not depend combinationally on any valid input.

## Structure
- Package axi_wr_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - burst codes BURST_FIXED/INCR/WRAP;
  - the W FSM state enum;
  - the AW queue entry struct.
- Sub-module axi_sync_fifo(WIDTH, DEPTH): single-clock FIFO with synchronous active-high reset, full/empty and count. It is instantiated twice, for the AW queue and the B queue.
- Beat-address generation is a function in the package.

## Test plan
- Single INCR, awaddr=0x1000, len=3, size=3, DW=64 → wr_addr 0x1000/0x1008/0x1010/0x1018; then bresp=00 with bid echoed, one cycle after the 4th beat.
- WRAP, awaddr=0x1018, len=3, size=3 → wr_addr 0x1018/0x1000/0x1008/0x1010; bresp=00.
- WLAST=1 on beat 1 of a len=3 burst → 4 beats still accepted, err_wlast=1, bresp=10. A following correct burst returns bresp=00.
- MAX_OUT=4: issue 5 AWs with s_bready=0 → the 5th is held with s_awready=0 and outstanding=4. One B handshake → s_awready=1 the next cycle and the 5th AW is accepted.
- size=4 with DW=64, and INCR at awaddr=0x0FF8 with len=1 size=3 → no wr_en pulses, both bursts bresp=10, and B order matches AW order.
- Reset asserted mid-burst (beat 2 of 4) → next cycle all outputs are at reset values. A new burst afterwards completes normally.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared types, codes and address helpers for the AXI write tracker.
package axi_wr_pkg;

  // Queue entries carry id/addr at a fixed carrier width; the top trims to IDW/AW.
  localparam int IDW_MAX = 16;
  localparam int AW_MAX  = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_e;

  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [AW_MAX-1:0]  addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               bad;
  } aw_entry_t;

  // Address of beat number 'beat' within a burst; beat 0 keeps the unaligned address.
  function automatic logic [AW_MAX-1:0] beat_addr(
    input logic [AW_MAX-1:0] addr,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst,
    input logic [7:0]        beat
  );
    logic [AW_MAX-1:0] off;
    logic [AW_MAX-1:0] wrap_mask;
    logic [AW_MAX-1:0] lsb_mask;
    off       = AW_MAX'(beat) << size;
    wrap_mask = ((AW_MAX'(len) + AW_MAX'(1)) << size) - AW_MAX'(1);
    lsb_mask  = (AW_MAX'(1) << size) - AW_MAX'(1);
    case (burst)
      BURST_INCR: beat_addr = (beat == 8'd0) ? addr : (addr & ~lsb_mask) + off;
      BURST_WRAP: beat_addr = (addr & ~wrap_mask) | ((addr + off) & wrap_mask);
      default:    beat_addr = addr;
    endcase
  endfunction

  // A burst is unserviceable if its size exceeds the bus, its type is reserved,
  // a WRAP length is illegal, or an INCR burst's last beat lands in another 4 KB page.
  function automatic logic aw_bad(
    input logic [11:0] addr_lo,
    input logic [7:0]  len,
    input logic [2:0]  size,
    input logic [1:0]  burst,
    input logic [2:0]  max_size
  );
    logic [15:0] start;
    logic [15:0] span;
    logic        wrap_len_ok;
    start       = {4'd0, addr_lo & ~((12'd1 << size) - 12'd1)};
    span        = 16'(len) << size;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    aw_bad = (size > max_size) || (burst == 2'b11) ||
             ((burst == BURST_WRAP) && !wrap_len_ok) ||
             ((burst == BURST_INCR) && ((start + span) > 16'h0FFF));
  endfunction

endpackage

// File: rtl/axi_wr_tracker_fifo.sv
// Single-clock FIFO with synchronous reset; head word is visible on rdata_o.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/axi_wr_tracker.sv
// AXI write slave: queues AW bursts, walks per-beat addresses, checks WLAST,
// and returns in-order B responses. Bursts live in the AW queue until their
// last beat, then move to the B queue, so outstanding = aw_count + b_count.
module axi_wr_tracker #(
  parameter int IDW     = 4,
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MAX_OUT = 4
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  input  logic [IDW-1:0]            s_awid,
  input  logic [AW-1:0]             s_awaddr,
  input  logic [7:0]                s_awlen,
  input  logic [2:0]                s_awsize,
  input  logic [1:0]                s_awburst,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DW-1:0]             s_wdata,
  input  logic [DW/8-1:0]           s_wstrb,
  input  logic                      s_wlast,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [IDW-1:0]            s_bid,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic                      wr_en,
  output logic [AW-1:0]             wr_addr,
  output logic [DW-1:0]             wr_data,
  output logic [DW/8-1:0]           wr_strb,
  output logic                      err_wlast,
  output logic [$clog2(MAX_OUT):0]  outstanding
);
  import axi_wr_pkg::*;

  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int BW = IDW + 2;
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);
  localparam logic [2:0]    MAX_SIZE = 3'($clog2(DW/8));

  aw_entry_t         aw_in, aw_head;
  logic              aw_full, aw_empty;
  logic [OW-1:0]     aw_count;
  logic [BW-1:0]     b_in, b_head;
  logic              b_full, b_empty;
  logic [OW-1:0]     b_count;

  w_state_e          state_q;
  logic [7:0]        beat_q;
  logic              berr_q;
  logic              err_wlast_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DW-1:0]     wr_data_q;
  logic [DW/8-1:0]   wr_strb_q;

  logic              aw_hs, w_hs, b_hs;
  logic              last_beat, wlast_mismatch, w_done, aw_more;
  logic [AW-1:0]     wr_addr_d;
  logic [1:0]        resp_d;

  assign outstanding = aw_count + b_count;
  assign s_awready   = (outstanding < OUT_MAX);
  assign s_wready    = (state_q == W_DATA);
  assign s_bvalid    = ~b_empty;
  assign s_bid       = b_empty ? '0 : b_head[BW-1:2];
  assign s_bresp     = b_empty ? RESP_OKAY : b_head[1:0];

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  assign aw_in = '{id:    IDW_MAX'(s_awid),
                   addr:  AW_MAX'(s_awaddr),
                   len:   s_awlen,
                   size:  s_awsize,
                   burst: s_awburst,
                   bad:   aw_bad(s_awaddr[11:0], s_awlen, s_awsize, s_awburst, MAX_SIZE)};

  assign last_beat      = (beat_q == aw_head.len);
  assign wlast_mismatch = s_wlast ^ last_beat;
  assign w_done         = w_hs & last_beat;
  assign aw_more        = |aw_count[OW-1:1];
  assign wr_addr_d      = AW'(beat_addr(aw_head.addr, aw_head.len, aw_head.size,
                                        aw_head.burst, beat_q));
  assign resp_d         = (aw_head.bad | berr_q | wlast_mismatch) ? RESP_SLVERR : RESP_OKAY;
  assign b_in           = {IDW'(aw_head.id), resp_d};

  axi_sync_fifo #(.WIDTH($bits(aw_entry_t)), .DEPTH(MAX_OUT)) u_aw_q (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (aw_hs & ~aw_full),
    .wdata_i (aw_in),
    .pop_i   (w_done),
    .rdata_o (aw_head),
    .full_o  (aw_full),
    .empty_o (aw_empty),
    .count_o (aw_count)
  );

  axi_sync_fifo #(.WIDTH(BW), .DEPTH(MAX_OUT)) u_b_q (
    .clk_i   (axi_aclk),
    .rst_i   (axi_areset),
    .push_i  (w_done & ~b_full),
    .wdata_i (b_in),
    .pop_i   (b_hs),
    .rdata_o (b_head),
    .full_o  (b_full),
    .empty_o (b_empty),
    .count_o (b_count)
  );

  // W channel FSM with registered backend beat and sticky WLAST error.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q     <= W_IDLE;
      beat_q      <= '0;
      berr_q      <= 1'b0;
      err_wlast_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strb_q   <= '0;
    end else begin
      wr_en_q <= w_hs & ~aw_head.bad;
      if (w_hs) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= s_wdata;
        wr_strb_q <= s_wstrb;
        if (wlast_mismatch) err_wlast_q <= 1'b1;
      end
      case (state_q)
        W_IDLE: begin
          if (!aw_empty) begin
            state_q <= W_DATA;
            beat_q  <= '0;
            berr_q  <= 1'b0;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              beat_q  <= '0;
              berr_q  <= 1'b0;
              state_q <= aw_more ? W_DATA : W_IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              berr_q <= berr_q | wlast_mismatch;
            end
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strb   = wr_strb_q;
  assign err_wlast = err_wlast_q;

endmodule

// File: tb/tb_axi_wr_tracker.sv
// Scoreboard bench for axi_wr_tracker.
module tb_axi_wr_tracker;
  import axi_wr_pkg::*;

  localparam int IDW = 4, AW = 32, DW = 64, MAX_OUT = 4;

  logic           axi_aclk = 1'b0;
  logic           axi_areset = 1'b1;
  logic [IDW-1:0] s_awid = '0;
  logic [AW-1:0]  s_awaddr = '0;
  logic [7:0]     s_awlen = '0;
  logic [2:0]     s_awsize = '0;
  logic [1:0]     s_awburst = '0;
  logic           s_awvalid = 1'b0;
  logic           s_awready;
  logic [DW-1:0]  s_wdata = '0;
  logic [7:0]     s_wstrb = '0;
  logic           s_wlast = 1'b0;
  logic           s_wvalid = 1'b0;
  logic           s_wready;
  logic [IDW-1:0] s_bid;
  logic [1:0]     s_bresp;
  logic           s_bvalid;
  logic           s_bready = 1'b0;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic [7:0]     wr_strb;
  logic           err_wlast;
  logic [2:0]     outstanding;

  always #5 axi_aclk = ~axi_aclk;

  axi_wr_tracker #(.IDW(IDW), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .err_wlast(err_wlast), .outstanding(outstanding)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; logic [63:0] data; logic [7:0] strb; } beat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [3:0] id; logic [31:0] addr; logic [7:0] len;
                   logic [2:0] size; logic [1:0] burst; } desc_t;

  beat_t exp_wr[$];
  bexp_t exp_b[$];
  desc_t pend[$];
  int    wr_pulses = 0;

  // Reference address walk: step beat by beat, wrapping at the container end.
  function automatic logic [31:0] model_addr(input desc_t d, input int beat);
    logic [31:0] bytes, total, base, a;
    bytes = 32'd1 << d.size;
    if (d.burst == BURST_INCR) begin
      if (beat == 0) return d.addr;
      return (d.addr / bytes) * bytes + 32'(beat) * bytes;
    end else if (d.burst == BURST_WRAP) begin
      total = (32'(d.len) + 32'd1) * bytes;
      base  = (d.addr / total) * total;
      a     = d.addr;
      for (int i = 0; i < beat; i++) begin
        a = a + bytes;
        if (a >= base + total) a = base;
      end
      return a;
    end
    return d.addr;
  endfunction

  function automatic logic model_bad(input desc_t d);
    logic [31:0] bytes, last;
    bytes = 32'd1 << d.size;
    last  = (d.addr / bytes) * bytes + 32'(d.len) * bytes;
    if (d.size > 3'd3) return 1'b1;
    if (d.burst == 2'b11) return 1'b1;
    if (d.burst == BURST_WRAP && !(d.len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
    if (d.burst == BURST_INCR && (d.addr >> 12) != (last >> 12)) return 1'b1;
    return 1'b0;
  endfunction

  // Output monitor: compare backend beats and B responses against the queues.
  always @(negedge axi_aclk) begin
    beat_t e;
    bexp_t b;
    if (wr_en) begin
      wr_pulses++;
      if (exp_wr.size() == 0) check_eq("wr_unexpected", 1, 0);
      else begin
        e = exp_wr.pop_front();
        check_eq("wr_addr", wr_addr, e.addr);
        check_eq("wr_data", wr_data, e.data);
        check_eq("wr_strb", wr_strb, e.strb);
      end
    end
    if (s_bvalid && s_bready) begin
      if (exp_b.size() == 0) check_eq("b_unexpected", 1, 0);
      else begin
        b = exp_b.pop_front();
        check_eq("bid", s_bid, b.id);
        check_eq("bresp", s_bresp, b.resp);
      end
    end
  end

  task automatic reset_check(input string p);
    check_eq({p, "_awready"}, s_awready, 1);
    check_eq({p, "_wready"}, s_wready, 0);
    check_eq({p, "_bvalid"}, s_bvalid, 0);
    check_eq({p, "_bid"}, s_bid, 0);
    check_eq({p, "_bresp"}, s_bresp, 0);
    check_eq({p, "_wr_en"}, wr_en, 0);
    check_eq({p, "_wr_addr"}, wr_addr, 0);
    check_eq({p, "_wr_data"}, wr_data, 0);
    check_eq({p, "_wr_strb"}, wr_strb, 0);
    check_eq({p, "_err_wlast"}, err_wlast, 0);
    check_eq({p, "_outstanding"}, outstanding, 0);
  endtask

  task automatic aw_send(input desc_t d);
    int n = 0;
    @(negedge axi_aclk);
    s_awid = d.id; s_awaddr = d.addr; s_awlen = d.len;
    s_awsize = d.size; s_awburst = d.burst; s_awvalid = 1'b1;
    while (!s_awready && n < 200) begin @(negedge axi_aclk); n++; end
    if (n >= 200) begin
      check_eq("aw_timeout", 0, 1);
      s_awvalid = 1'b0;
      return;
    end
    pend.push_back(d);
    @(posedge axi_aclk); #1 s_awvalid = 1'b0;
  endtask

  // Sends up to n_send beats of the oldest accepted burst; WLAST is driven on beat wl_beat.
  task automatic w_burst(input int wl_beat, input int n_send, input bit chk_blat, output int stalls);
    desc_t d;
    logic  bad;
    bexp_t be;
    beat_t e;
    int    n;
    stalls = 0;
    if (pend.size() == 0) begin check_eq("w_no_desc", 0, 1); return; end
    d   = pend.pop_front();
    bad = model_bad(d);
    for (int b = 0; b <= int'(d.len) && b < n_send; b++) begin
      n = 0;
      e.addr = model_addr(d, b);
      e.data = {$urandom, $urandom};
      e.strb = 8'($urandom);
      @(negedge axi_aclk);
      s_wdata = e.data; s_wstrb = e.strb; s_wlast = (b == wl_beat); s_wvalid = 1'b1;
      if (!bad) exp_wr.push_back(e);
      if (b == int'(d.len)) begin
        be.id   = d.id;
        be.resp = (bad || wl_beat != int'(d.len)) ? RESP_SLVERR : RESP_OKAY;
        exp_b.push_back(be);
      end
      while (!s_wready && n < 200) begin @(negedge axi_aclk); n++; end
      stalls += n;
      if (n >= 200) begin
        check_eq("w_timeout", 0, 1);
        s_wvalid = 1'b0;
        return;
      end
      @(posedge axi_aclk); #1 s_wvalid = 1'b0;
    end
    if (chk_blat) begin
      @(negedge axi_aclk);
      check_eq("bvalid_latency", s_bvalid, 1);
    end
  endtask

  task automatic wait_drain(input string p);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_b.size() != 0) && n < 200) begin
      @(negedge axi_aclk); n++;
    end
    if (n >= 200) check_eq({p, "_drain_timeout"}, 0, 1);
    @(negedge axi_aclk);
    check_eq({p, "_outstanding"}, outstanding, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2, p;
    desc_t d5;
    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    reset_check("rst");
    @(posedge axi_aclk); #1 axi_areset = 1'b0; s_bready = 1'b1;

    // single INCR, response one cycle after the last beat
    aw_send('{4'd5, 32'h1000, 8'd3, 3'd3, BURST_INCR});
    w_burst(3, 256, 1'b1, st);
    wait_drain("incr");

    // WRAP from mid-container
    aw_send('{4'd9, 32'h1018, 8'd3, 3'd3, BURST_WRAP});
    w_burst(3, 256, 1'b1, st);
    wait_drain("wrap");
    check_eq("err_wlast_clean", err_wlast, 0);

    // early WLAST, then a clean burst
    aw_send('{4'd3, 32'h3000, 8'd3, 3'd3, BURST_INCR});
    w_burst(1, 256, 1'b0, st);
    wait_drain("wlast_bad");
    check_eq("err_wlast_set", err_wlast, 1);
    aw_send('{4'd4, 32'h3100, 8'd7, 3'd2, BURST_INCR});
    w_burst(7, 256, 1'b0, st);
    wait_drain("wlast_ok");
    check_eq("err_wlast_sticky", err_wlast, 1);

    // back-to-back bursts with no bubble
    aw_send('{4'd6, 32'h4000, 8'd3, 3'd3, BURST_INCR});
    aw_send('{4'd7, 32'h5020, 8'd3, 3'd3, BURST_WRAP});
    w_burst(3, 256, 1'b0, st);
    w_burst(3, 256, 1'b0, st2);
    check_eq("b2b_stalls", st2, 0);
    wait_drain("b2b");

    // fill to MAX_OUT with B held off
    @(posedge axi_aclk); #1 s_bready = 1'b0;
    for (int i = 0; i < 4; i++)
      aw_send('{4'(8 + i), 32'h6000 + 32'(i * 8), 8'd0, 3'd3, BURST_INCR});
    for (int i = 0; i < 4; i++) w_burst(0, 256, 1'b0, st);
    d5 = '{4'd12, 32'h6100, 8'd0, 3'd3, BURST_INCR};
    @(negedge axi_aclk);
    s_awid = d5.id; s_awaddr = d5.addr; s_awlen = d5.len;
    s_awsize = d5.size; s_awburst = d5.burst; s_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("full_awready", s_awready, 0);
      check_eq("full_outstanding", outstanding, 4);
      @(negedge axi_aclk);
    end
    @(posedge axi_aclk); #1 s_bready = 1'b1;
    @(posedge axi_aclk); #1 s_bready = 1'b0;
    @(negedge axi_aclk);
    check_eq("after_b_awready", s_awready, 1);
    check_eq("after_b_outstanding", outstanding, 3);
    pend.push_back(d5);
    @(posedge axi_aclk); #1 s_awvalid = 1'b0;
    @(negedge axi_aclk);
    check_eq("fifth_outstanding", outstanding, 4);
    w_burst(0, 256, 1'b0, st);
    @(posedge axi_aclk); #1 s_bready = 1'b1;
    wait_drain("maxout");

    // unserviceable bursts: oversize and 4 KB crossing
    p = wr_pulses;
    aw_send('{4'd1, 32'h2000, 8'd1, 3'd4, BURST_INCR});
    aw_send('{4'd2, 32'h0FF8, 8'd1, 3'd3, BURST_INCR});
    w_burst(1, 256, 1'b0, st);
    w_burst(1, 256, 1'b0, st);
    wait_drain("bad");
    check_eq("bad_no_wr", wr_pulses, p);

    // reset during beat 2 of 4
    aw_send('{4'd13, 32'h7000, 8'd3, 3'd3, BURST_INCR});
    w_burst(3, 2, 1'b0, st);
    axi_areset = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    reset_check("midrst");
    @(posedge axi_aclk); #1 axi_areset = 1'b0;
    aw_send('{4'd14, 32'h8000, 8'd2, 3'd3, BURST_INCR});
    w_burst(2, 256, 1'b1, st);
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
